// File: rtl/byte_reader_pkg.sv
// ---------------------------------------------------------------------------
// byte_reader_pkg
// Shared definitions for the byte reader slice.
//   state_t       : FSM state encoding (fixed 2-bit values)
//   DEFAULT_WIDTH : default stored-word width in bits
//   cnt_width()   : bit counter width for a given word width
// Optional feature macro used by this slice: BYTE_READER_PARITY_EN
// ---------------------------------------------------------------------------
package byte_reader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter is cleared on every accept, so it only ever needs to reach
    // WIDTH-1. A one-bit floor keeps the vector legal for tiny widths.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/byte_reader_if.sv
// ---------------------------------------------------------------------------
// byte_reader_if
// Bus between the byte memory / requester side and the byte reader.
//   memory       : parallel word from byte memory
//   read_req     : level request to start a read
//   busy         : reader is not idle
//   serial_out   : current serial bit (0 when serial_valid is low)
//   serial_valid : a data or parity bit is on serial_out this cycle
//   done         : one-cycle pulse after the last bit
// Modports: master (requester side), slave (byte_reader).
// ---------------------------------------------------------------------------
interface byte_reader_if
    import byte_reader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] memory;
    logic             read_req;
    logic             busy;
    logic             serial_out;
    logic             serial_valid;
    logic             done;

    modport master (
        output memory,
        output read_req,
        input  busy,
        input  serial_out,
        input  serial_valid,
        input  done
    );

    modport slave (
        input  memory,
        input  read_req,
        output busy,
        output serial_out,
        output serial_valid,
        output done
    );

endinterface

// File: rtl/byte_reader_bit_counter.sv
// ---------------------------------------------------------------------------
// bit_counter
// Clear/enable counter that tracks how many bits have been shifted out, with
// a terminal flag raised when the count reaches WIDTH-1.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   clear    : synchronous clear (wins over enable)
//   enable   : increment by one
//   terminal : count == WIDTH-1
// ---------------------------------------------------------------------------
module bit_counter
    import byte_reader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] count;

    // Count register: clear has priority so a fresh read always starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Terminal flag marks the cycle that carries the last data bit.
    assign terminal = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/byte_reader.sv
// ---------------------------------------------------------------------------
// byte_reader
// Snapshots the stored word on request and shifts it out LSB first with a
// valid strobe, then issues a one-cycle done pulse.
//   clk   : system clock, rising-edge
//   reset : asynchronous active-high reset
//   bus   : byte_reader_if.slave (memory, read_req in; busy, serial_out,
//           serial_valid, done out)
// Optional: define BYTE_READER_PARITY_EN to append an even-parity bit
// (XOR of the snapshot) after the data bits, delaying done by one cycle.
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module byte_reader
    import byte_reader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    byte_reader_if.slave  bus
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shift_reg;
    logic             accept;
    logic             last_bit;
`ifdef BYTE_READER_PARITY_EN
    logic             parity_bit;
`endif

    // A request is only honoured while idle; requests during a read or the
    // done cycle are dropped rather than queued.
    assign accept = (state == IDLE) && bus.read_req;

    // The counter is cleared on accept and advances once per shifted bit.
    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .enable   (state == SHIFT),
        .terminal (last_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: the done state always lasts exactly one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.read_req) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef BYTE_READER_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = DONE;
`endif
                end
            end
`ifdef BYTE_READER_PARITY_EN
            PARITY: begin
                next_state = DONE;
            end
`endif
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Snapshot register: loaded only on accept so memory rewrites during a
    // read cannot disturb the word in flight; zero-filled as it shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (accept) begin
            shift_reg <= bus.memory;
        end else if (state == SHIFT) begin
            shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
        end
    end

`ifdef BYTE_READER_PARITY_EN
    // Parity is taken from the snapshot at accept, since the shift register
    // no longer holds the full word by the time the parity bit is sent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^bus.memory;
        end
    end
`endif

    // Output decode from registered state; reset forces everything low
    // immediately because the state register clears asynchronously.
    always_comb begin
        bus.busy         = (state != IDLE);
        bus.done         = (state == DONE);
        bus.serial_valid = 1'b0;
        bus.serial_out   = 1'b0;
        if (state == SHIFT) begin
            bus.serial_valid = 1'b1;
            bus.serial_out   = shift_reg[0];
        end
`ifdef BYTE_READER_PARITY_EN
        if (state == PARITY) begin
            bus.serial_valid = 1'b1;
            bus.serial_out   = parity_bit;
        end
`endif
    end

endmodule

// File: tb/tb_byte_reader.sv
// ---------------------------------------------------------------------------
// tb_byte_reader
// Self-checking bench for byte_reader. A reference model turns each accepted
// read into a queue of expected per-cycle outputs (busy, valid, out, done);
// directed scenarios add literal checks on bit order and pulse timing.
// Honours BYTE_READER_PARITY_EN when defined.
// ---------------------------------------------------------------------------
module tb_byte_reader;

    localparam int W = 8;
`ifdef BYTE_READER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic busy;
        logic valid;
        logic out;
        logic done;
    } obs_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    obs_t exp_q[$];

    byte_reader_if #(.WIDTH(W)) bus ();

    byte_reader #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs of the current cycle: front of the queue, or idle.
    function automatic obs_t exp_now();
        obs_t e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q[0];
        return e;
    endfunction

    function automatic obs_t act_now();
        return {bus.busy, bus.serial_valid, bus.serial_out, bus.done};
    endfunction

    // One accepted read: W data cycles LSB first, optional parity, then done.
    task automatic push_frame(input logic [W-1:0] word);
        for (int i = 0; i < W; i++) exp_q.push_back({1'b1, 1'b1, word[i], 1'b0});
        if (PAR == 1) exp_q.push_back({1'b1, 1'b1, ^word, 1'b0});
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1});
    endtask

    // Advance one clock; the model consumes a cycle or, when idle, accepts.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else if (bus.read_req) begin
            push_frame(bus.memory);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.read_req = 1'b1;
        bus.memory = 8'h5A;
        exp_q.delete();
        tick();
        tick();
        #1;
        total++;
        if (act_now() !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_held: got %b want 0000", act_now());
        end
        reset = 1'b0;
        bus.read_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            bus.memory = 8'($urandom);
            #1;
            total++;
            if (act_now() !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL idle_after_reset c%0d: got %b want 0000", c, act_now());
            end
        end
    endtask

    task automatic test_single_read();
        logic [W-1:0] got;
        int done_cyc;
        got = '0;
        done_cyc = -1;
        bus.memory = 8'hA5;
        bus.read_req = 1'b1;
        tick();
        for (int c = 1; c <= 12; c++) begin
            bus.read_req = 1'b0;
            bus.memory = 8'($urandom);
            #1;
            total++;
            if (act_now() !== exp_now()) begin
                bad++;
                $display("[TB] FAIL single_read c%0d: got %b want %b", c, act_now(), exp_now());
            end
            if (c <= W && bus.serial_valid) got[c-1] = bus.serial_out;
            if (bus.done && done_cyc < 0) done_cyc = c;
            tick();
        end
        total++;
        if (got !== 8'hA5) begin
            bad++;
            $display("[TB] FAIL single_read_bits: got %h want a5", got);
        end
        total++;
        if (done_cyc != W + 1 + PAR) begin
            bad++;
            $display("[TB] FAIL single_read_done_cycle: got %0d want %0d", done_cyc, W + 1 + PAR);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got;
        int done_cyc;
        int next_cyc;
        got = '0;
        done_cyc = -1;
        next_cyc = -1;
        bus.memory = 8'h3C;
        bus.read_req = 1'b1;
        tick();
        for (int c = 1; c <= 26; c++) begin
            bus.memory = 8'hFF;
            bus.read_req = (c >= 2 && c <= 10 + PAR);
            #1;
            total++;
            if (act_now() !== exp_now()) begin
                bad++;
                $display("[TB] FAIL back_to_back c%0d: got %b want %b", c, act_now(), exp_now());
            end
            if (c <= W && bus.serial_valid) got[c-1] = bus.serial_out;
            if (bus.done && done_cyc < 0) done_cyc = c;
            if (done_cyc > 0 && c > done_cyc && bus.serial_valid && next_cyc < 0) next_cyc = c;
            tick();
        end
        total++;
        if (got !== 8'h3C) begin
            bad++;
            $display("[TB] FAIL b2b_bits: got %h want 3c", got);
        end
        total++;
        if (next_cyc - done_cyc != 2) begin
            bad++;
            $display("[TB] FAIL b2b_gap: got %0d want 2", next_cyc - done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] got;
        int dones;
        bus.memory = 8'hFF;
        bus.read_req = 1'b1;
        tick();
        bus.read_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            total++;
            if (act_now() !== exp_now()) begin
                bad++;
                $display("[TB] FAIL pre_reset c%0d: got %b want %b", c, act_now(), exp_now());
            end
            tick();
        end
        reset = 1'b1;
        exp_q.delete();
        #1;
        total++;
        if (act_now() !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL async_reset: got %b want 0000", act_now());
        end
        tick();
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.done) dones++;
            tick();
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("[TB] FAIL no_done_after_reset: got %0d want 0", dones);
        end
        got = '0;
        bus.memory = 8'h01;
        bus.read_req = 1'b1;
        tick();
        for (int c = 1; c <= W + 2 + PAR; c++) begin
            bus.read_req = 1'b0;
            #1;
            total++;
            if (act_now() !== exp_now()) begin
                bad++;
                $display("[TB] FAIL post_reset_read c%0d: got %b want %b", c, act_now(), exp_now());
            end
            if (c <= W && bus.serial_valid) got[c-1] = bus.serial_out;
            tick();
        end
        total++;
        if (got !== 8'h01) begin
            bad++;
            $display("[TB] FAIL post_reset_bits: got %h want 01", got);
        end
    endtask

`ifdef BYTE_READER_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        logic       pbits [2];
        words[0] = 8'h07;
        words[1] = 8'h03;
        pbits[0] = 1'b1;
        pbits[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.memory = words[k];
            bus.read_req = 1'b1;
            tick();
            bus.read_req = 1'b0;
            for (int c = 1; c <= W + 3; c++) begin
                #1;
                if (c == W + 1) begin
                    total++;
                    if ({bus.serial_valid, bus.serial_out, bus.done} !== {1'b1, pbits[k], 1'b0}) begin
                        bad++;
                        $display("[TB] FAIL parity_bit w%h: got v%b o%b d%b want v1 o%b d0", words[k], bus.serial_valid, bus.serial_out, bus.done, pbits[k]);
                    end
                end
                if (c == W + 2) begin
                    total++;
                    if ({bus.serial_valid, bus.done} !== 2'b01) begin
                        bad++;
                        $display("[TB] FAIL parity_done w%h: got v%b d%b want v0 d1", words[k], bus.serial_valid, bus.done);
                    end
                end
                tick();
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.memory = 8'($urandom);
            bus.read_req = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 79) == 0) begin
                reset = 1'b1;
                exp_q.delete();
            end else begin
                reset = 1'b0;
            end
            #1;
            total++;
            if (act_now() !== exp_now()) begin
                bad++;
                $display("[TB] FAIL random c%0d: got %b want %b", c, act_now(), exp_now());
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        bus.read_req = 1'b0;
        bus.memory = '0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_reset_mid();
`ifdef BYTE_READER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
